// File: rtl/intra4x4_mode_decider_if.sv
`default_nettype none
// ============================================================================
// Module   : intra4x4_mode_decider_if
// Brief    : Block-in / result-out handshake bundle for the intra 4x4 decider.
// Revision : 1.0
// ============================================================================
interface intra4x4_mode_decider_if #(
  parameter int SAD_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*SAD_W-1:0]   sads_in;
  logic [7:0]           mode_mask;
  logic [3:0]           mpm;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           best_slot;
  logic [3:0]           best_mode;
  logic [SAD_W:0]       best_cost;
  logic                 none_valid;

  modport slave (
    input  in_valid, sads_in, mode_mask, mpm, out_ready,
    output in_ready, out_valid, best_slot, best_mode, best_cost, none_valid
  );

  modport master (
    output in_valid, sads_in, mode_mask, mpm, out_ready,
    input  in_ready, out_valid, best_slot, best_mode, best_cost, none_valid
  );
endinterface
`default_nettype wire

// File: rtl/intra4x4_mode_decider.sv
`default_nettype none
// ============================================================================
// Module   : intra4x4_mode_decider
// Brief    : Serial cheapest-mode search over eight intra 4x4 SADs with MPM bias.
// Revision : 1.0
// ============================================================================
module intra4x4_mode_decider #(
  parameter int SAD_W   = 8,
  parameter int PENALTY = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  intra4x4_mode_decider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SAD_W:0] c_penalty  = (SAD_W+1)'(PENALTY);
  localparam logic [SAD_W:0] c_all_ones = '1;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_k;
  logic [8*SAD_W-1:0]   r_sads;
  logic [7:0]           r_mask;
  logic [3:0]           r_mpm;
  logic [SAD_W:0]       r_best;
  logic [2:0]           r_run_slot;
  logic                 r_found;
  logic [2:0]           r_best_slot;
  logic [3:0]           r_best_mode;
  logic [SAD_W:0]       r_best_cost;
  logic                 r_none_valid;

  logic [SAD_W-1:0]     w_sad;
  logic [SAD_W:0]       w_cost;
  logic                 w_take;
  logic [SAD_W:0]       w_new_best;
  logic [2:0]           w_new_slot;
  logic                 w_new_found;

  // Slot order V,H,VL,VR,HU,HD,DDL,DDR mapped to H.264 intra 4x4 mode numbers
  function automatic logic [3:0] slot2mode(input logic [2:0] s);
    case (s)
      3'd0:    slot2mode = 4'd0;
      3'd1:    slot2mode = 4'd1;
      3'd2:    slot2mode = 4'd7;
      3'd3:    slot2mode = 4'd5;
      3'd4:    slot2mode = 4'd8;
      3'd5:    slot2mode = 4'd6;
      3'd6:    slot2mode = 4'd3;
      default: slot2mode = 4'd4;
    endcase
  endfunction

  always_comb begin
    w_sad       = r_sads[r_k*SAD_W +: SAD_W];
    w_cost      = {1'b0, w_sad} + ((slot2mode(r_k) == r_mpm) ? '0 : c_penalty);
    // Strict less-than keeps the lowest slot on ties
    w_take      = r_mask[r_k] && (!r_found || (w_cost < r_best));
    w_new_best  = w_take ? w_cost : r_best;
    w_new_slot  = w_take ? r_k    : r_run_slot;
    w_new_found = r_found | w_take;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = SCAN;
      SCAN:    if (r_k == 3'd7)   w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k          <= '0;
      r_sads       <= '0;
      r_mask       <= '0;
      r_mpm        <= '0;
      r_best       <= '0;
      r_run_slot   <= '0;
      r_found      <= 1'b0;
      r_best_slot  <= '0;
      r_best_mode  <= '0;
      r_best_cost  <= '0;
      r_none_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sads     <= bus.sads_in;
            r_mask     <= bus.mode_mask;
            r_mpm      <= bus.mpm;
            r_best     <= c_all_ones;
            r_run_slot <= '0;
            r_found    <= 1'b0;
            r_k        <= '0;
          end
        end
        SCAN: begin
          r_k        <= r_k + 3'd1;
          r_best     <= w_new_best;
          r_run_slot <= w_new_slot;
          r_found    <= w_new_found;
          if (r_k == 3'd7) begin
            if (w_new_found) begin
              r_best_slot  <= w_new_slot;
              r_best_mode  <= slot2mode(w_new_slot);
              r_best_cost  <= w_new_best;
              r_none_valid <= 1'b0;
            end else begin
              r_best_slot  <= '0;
              r_best_mode  <= '0;
              r_best_cost  <= c_all_ones;
              r_none_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.best_slot  = r_best_slot;
  assign bus.best_mode  = r_best_mode;
  assign bus.best_cost  = r_best_cost;
  assign bus.none_valid = r_none_valid;

endmodule
`default_nettype wire
